// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command sequencer slice:
//   - seq_state_t     : sequencer FSM states
//   - GRP_*           : opcode group codes, taken from opcode bits [3:2]
//   - STAT_*          : bit positions inside the 4-bit ALU status word
//   - is_illegal_group: true for the group that has no ALU behind it
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DELIVER = 2'd3
  } seq_state_t;

  localparam logic [1:0] GRP_ARITH   = 2'b00;
  localparam logic [1:0] GRP_LOGIC   = 2'b01;
  localparam logic [1:0] GRP_SHIFT   = 2'b10;
  localparam logic [1:0] GRP_ILLEGAL = 2'b11;

  localparam int STAT_ZERO   = 0;
  localparam int STAT_CARRY  = 1;
  localparam int STAT_PARITY = 2;
  localparam int STAT_NEG    = 3;

  // Group 2'b11 is not backed by any ALU function.
  function automatic logic is_illegal_group(input logic [1:0] grp);
    return (grp == GRP_ILLEGAL);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// Command queue in front of the sequencer FSM. Power-of-two depth, so the
// read and write pointers wrap naturally.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-low reset
//   i_push, i_data   write one command (ignored while full)
//   i_pop            drop the head entry (ignored while empty)
//   o_data           current head entry (valid when o_empty is 0)
//   o_count          occupancy, 0..DEPTH
//   o_full, o_empty  occupancy flags
// -----------------------------------------------------------------------------
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (o_count == FULL_COUNT);
  assign o_empty = (o_count == '0);
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;
  assign o_data  = mem[rd_ptr];

  // Storage array; no reset needed since occupancy decides what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy. A push and a pop on the same edge cancel out
  // in the count while both pointers still advance.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Queues ALU commands and runs them one at a time through an external,
// registered ALU: issue operands, capture the ALU result one edge later,
// then hold it for the downstream consumer.
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-low reset
//   i_valid/o_ready, i_op,
//   i_arg_A, i_arg_B               upstream command handshake
//   o_alu_op, o_alu_arg_A/B        operands held towards the ALU
//   i_alu_result, i_alu_status     registered ALU outputs
//   o_valid/i_ready, o_result,
//   o_status, o_illegal            downstream result handshake
//   o_count                        command FIFO occupancy
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int M     = 8,
  parameter int K     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [N-1:0]           i_op,
  input  logic [M-1:0]           i_arg_A,
  input  logic [M-1:0]           i_arg_B,
  output logic [N-1:0]           o_alu_op,
  output logic [M-1:0]           o_alu_arg_A,
  output logic [M-1:0]           o_alu_arg_B,
  input  logic [K-1:0]           i_alu_result,
  input  logic [3:0]             i_alu_status,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [K-1:0]           o_result,
  output logic [3:0]             o_status,
  output logic                   o_illegal,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int CMD_W = N + 2*M;

  seq_state_t       state;
  logic [CMD_W-1:0] head;
  logic [N-1:0]     head_op;
  logic [M-1:0]     head_a;
  logic [M-1:0]     head_b;
  logic             head_illegal;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             ready_en;
  logic             pend_illegal;

  // ready_en keeps o_ready low through reset and for the cycle after release.
  assign o_ready   = ready_en & ~fifo_full;
  assign fifo_push = i_valid & o_ready;

  assign head_op      = head[CMD_W-1 -: N];
  assign head_a       = head[2*M-1 -: M];
  assign head_b       = head[M-1:0];
  assign head_illegal = is_illegal_group(head_op[3:2]);

  // A new command is taken whenever the FSM is free: idle, or the result
  // being delivered is accepted on this edge.
  assign fifo_pop = ~fifo_empty &
                    ((state == ST_IDLE) | ((state == ST_DELIVER) & i_ready));

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (fifo_push),
    .i_data  ({i_op, i_arg_A, i_arg_B}),
    .i_pop   (fifo_pop),
    .o_data  (head),
    .o_count (o_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Sequencer FSM with all outputs registered. The case statement handles
  // the fixed progressions; the fifo_pop block afterwards overrides the next
  // state whenever a command is taken. Illegal opcodes never touch the ALU
  // operands and jump to CAPTURE, which then loads the zero result with
  // o_illegal set, so they are delivered one cycle earlier than ALU commands.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= ST_IDLE;
      ready_en     <= 1'b0;
      pend_illegal <= 1'b0;
      o_alu_op     <= '0;
      o_alu_arg_A  <= '0;
      o_alu_arg_B  <= '0;
      o_valid      <= 1'b0;
      o_result     <= '0;
      o_status     <= '0;
      o_illegal    <= 1'b0;
    end else begin
      ready_en <= 1'b1;

      case (state)
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        ST_ISSUE: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state   <= ST_DELIVER;
          o_valid <= 1'b1;
          if (pend_illegal) begin
            o_result  <= '0;
            o_status  <= 4'b0000;
            o_illegal <= 1'b1;
          end else begin
            o_result  <= i_alu_result;
            o_status  <= i_alu_status;
            o_illegal <= 1'b0;
          end
        end
        ST_DELIVER: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (fifo_pop) begin
        pend_illegal <= head_illegal;
        if (head_illegal) begin
          state <= ST_CAPTURE;
        end else begin
          state       <= ST_ISSUE;
          o_alu_op    <= head_op;
          o_alu_arg_A <= head_a;
          o_alu_arg_B <= head_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Self-checking bench: a registered ALU model sits behind the DUT, expected
// results are queued when a command is accepted and compared when the DUT
// hands a result downstream.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int N     = 4;
  localparam int M     = 8;
  localparam int K     = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] stat;
    logic       ill;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [3:0] stat;
    logic       ill;
  } exp_t;

  logic                   i_clk   = 1'b0;
  logic                   i_reset = 1'b0;
  logic                   i_valid = 1'b0;
  logic                   i_ready = 1'b0;
  logic [N-1:0]           i_op    = '0;
  logic [M-1:0]           i_arg_A = '0;
  logic [M-1:0]           i_arg_B = '0;
  logic                   o_ready;
  logic [N-1:0]           o_alu_op;
  logic [M-1:0]           o_alu_arg_A;
  logic [M-1:0]           o_alu_arg_B;
  logic [K-1:0]           alu_result = '0;
  logic [3:0]             alu_status = '0;
  logic                   o_valid;
  logic [K-1:0]           o_result;
  logic [3:0]             o_status;
  logic                   o_illegal;
  logic [$clog2(DEPTH):0] o_count;

  vec_t tbl [12];
  exp_t sb [$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_cmd_sequencer #(
    .N     (N),
    .M     (M),
    .K     (K),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_op         (i_op),
    .i_arg_A      (i_arg_A),
    .i_arg_B      (i_arg_B),
    .o_alu_op     (o_alu_op),
    .o_alu_arg_A  (o_alu_arg_A),
    .o_alu_arg_B  (o_alu_arg_B),
    .i_alu_result (alu_result),
    .i_alu_status (alu_status),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result),
    .o_status     (o_status),
    .o_illegal    (o_illegal),
    .o_count      (o_count)
  );

  always #5 i_clk = ~i_clk;

  // Reference ALU: returns {status, result}.
  function automatic logic [11:0] alu_model(input logic [3:0] op,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
    logic [8:0] wide;
    logic [7:0] res;
    logic [3:0] st;
    case (op)
      4'b0000: wide = {1'b0, a} - {1'b0, b};
      4'b0001: wide = {1'b0, a} + {1'b0, b};
      4'b0100: wide = {1'b0, a & b};
      4'b0101: wide = {1'b0, a | b};
      4'b0110: wide = {1'b0, a ^ b};
      4'b1000: wide = {1'b0, a << b[2:0]};
      4'b1001: wide = {1'b0, a >> b[2:0]};
      default: wide = {1'b0, a};
    endcase
    res = wide[7:0];
    st = 4'b0000;
    st[STAT_ZERO]   = (res == 8'h00);
    st[STAT_CARRY]  = wide[8];
    st[STAT_PARITY] = ^res;
    st[STAT_NEG]    = res[7];
    return {st, res};
  endfunction

  function automatic vec_t make_vec(input logic [3:0] op,
                                    input logic [7:0] a,
                                    input logic [7:0] b);
    vec_t       v;
    logic [11:0] r;
    v.op = op;
    v.a  = a;
    v.b  = b;
    if (op[3:2] == 2'b11) begin
      v.res  = 8'h00;
      v.stat = 4'b0000;
      v.ill  = 1'b1;
    end else begin
      r      = alu_model(op, a, b);
      v.res  = r[7:0];
      v.stat = r[11:8];
      v.ill  = 1'b0;
    end
    return v;
  endfunction

  // Registered ALU sitting behind the DUT operand outputs.
  always @(posedge i_clk) begin
    {alu_status, alu_result} <= alu_model(o_alu_op, o_alu_arg_A, o_alu_arg_B);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  // Holds i_valid until the command is accepted; queues its expected result
  // at the moment the handshake is known to happen on the coming edge.
  task automatic applyStimulus(input vec_t v);
    bit   done;
    exp_t e;
    done    = 1'b0;
    i_valid = 1'b1;
    i_op    = v.op;
    i_arg_A = v.a;
    i_arg_B = v.b;
    for (int t = 0; t < 300 && !done; t++) begin
      if (o_ready) begin
        e.res  = v.res;
        e.stat = v.stat;
        e.ill  = v.ill;
        sb.push_back(e);
        done = 1'b1;
      end
      step(1);
    end
    i_valid = 1'b0;
    checkOutput("push_accepted", 32'(done), 32'd1);
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    while (!o_valid && cycles < 50) begin
      step(1);
      cycles++;
    end
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while ((sb.size() != 0 || o_valid || o_count != 0) && t < 300) begin
      step(1);
      t++;
    end
    checkOutput("drain_done", 32'(t < 300), 32'd1);
  endtask

  // Scoreboard side: every result accepted downstream is compared in order.
  always @(negedge i_clk) begin
    if (i_reset && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_delivery", 32'(o_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("result",  32'(o_result),  32'(mon_e.res));
        checkOutput("status",  32'(o_status),  32'(mon_e.stat));
        checkOutput("illegal", 32'(o_illegal), 32'(mon_e.ill));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cyc;
    int   gap;
    vec_t rv;

    tbl[0]  = '{4'b0001, 8'h03, 8'h04, 8'h07, 4'b0100, 1'b0};
    tbl[1]  = '{4'b0001, 8'hF0, 8'h20, 8'h10, 4'b0110, 1'b0};
    tbl[2]  = '{4'b0000, 8'h05, 8'h05, 8'h00, 4'b0001, 1'b0};
    tbl[3]  = '{4'b0000, 8'h03, 8'h05, 8'hFE, 4'b1110, 1'b0};
    tbl[4]  = '{4'b0100, 8'hCC, 8'hAA, 8'h88, 4'b1000, 1'b0};
    tbl[5]  = '{4'b0101, 8'h0F, 8'h30, 8'h3F, 4'b0000, 1'b0};
    tbl[6]  = '{4'b0110, 8'hFF, 8'h0F, 8'hF0, 4'b1000, 1'b0};
    tbl[7]  = '{4'b1000, 8'h81, 8'h01, 8'h02, 4'b0100, 1'b0};
    tbl[8]  = '{4'b1001, 8'h80, 8'h03, 8'h10, 4'b0100, 1'b0};
    tbl[9]  = '{4'b1100, 8'h12, 8'h34, 8'h00, 4'b0000, 1'b1};
    tbl[10] = '{4'b1111, 8'hAB, 8'hCD, 8'h00, 4'b0000, 1'b1};
    tbl[11] = '{4'b0010, 8'h5A, 8'h00, 8'h5A, 4'b0000, 1'b0};

    $display("[TB] reset phase");
    i_reset = 1'b0;
    step(3);
    checkOutput("rst_o_ready",  32'(o_ready),  32'd0);
    checkOutput("rst_o_valid",  32'(o_valid),  32'd0);
    checkOutput("rst_o_count",  32'(o_count),  32'd0);
    checkOutput("rst_o_result", 32'(o_result), 32'd0);
    checkOutput("rst_o_alu_op", 32'(o_alu_op), 32'd0);
    i_reset = 1'b1;
    #1;
    checkOutput("ready_before_first_edge", 32'(o_ready), 32'd0);
    step(1);
    checkOutput("ready_after_first_edge", 32'(o_ready), 32'd1);

    $display("[TB] single command latency");
    i_ready = 1'b1;
    applyStimulus(tbl[0]);
    waitValid(cyc);
    checkOutput("latency_legal", 32'(cyc), 32'd3);
    waitDrain();

    $display("[TB] illegal opcode bypass");
    applyStimulus(tbl[9]);
    waitValid(cyc);
    checkOutput("latency_illegal", 32'(cyc), 32'd2);
    checkOutput("illegal_alu_op_held", 32'(o_alu_op),    32'(tbl[0].op));
    checkOutput("illegal_alu_a_held",  32'(o_alu_arg_A), 32'(tbl[0].a));
    checkOutput("illegal_alu_b_held",  32'(o_alu_arg_B), 32'(tbl[0].b));
    waitDrain();

    $display("[TB] throughput with i_ready high");
    applyStimulus(tbl[1]);
    applyStimulus(tbl[2]);
    waitValid(cyc);
    gap = 0;
    do begin
      step(1);
      gap++;
    end while (!o_valid && gap < 20);
    checkOutput("result_interval", 32'(gap), 32'd3);
    waitDrain();

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i]);
    end
    waitDrain();

    $display("[TB] fill with downstream stalled");
    i_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(tbl[i]);
    end
    // The first command is already in flight, so four pushes leave three queued.
    checkOutput("fill_count_after_4", 32'(o_count), 32'd3);
    checkOutput("fill_valid_after_4", 32'(o_valid), 32'd1);
    checkOutput("fill_ready_after_4", 32'(o_ready), 32'd1);
    applyStimulus(tbl[5]);
    checkOutput("full_count", 32'(o_count), 32'd4);
    checkOutput("full_ready", 32'(o_ready), 32'd0);
    fork
      begin
        applyStimulus(tbl[6]);
      end
      begin
        for (int c = 0; c < 10; c++) begin
          step(1);
          checkOutput("hold_valid",   32'(o_valid),     32'd1);
          checkOutput("hold_result",  32'(o_result),    32'(tbl[1].res));
          checkOutput("hold_status",  32'(o_status),    32'(tbl[1].stat));
          checkOutput("hold_illegal", 32'(o_illegal),   32'd0);
          checkOutput("hold_alu_op",  32'(o_alu_op),    32'(tbl[1].op));
          checkOutput("hold_alu_a",   32'(o_alu_arg_A), 32'(tbl[1].a));
          checkOutput("hold_alu_b",   32'(o_alu_arg_B), 32'(tbl[1].b));
        end
        checkOutput("full_push_ignored", 32'(o_count), 32'd4);
        i_ready = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] simultaneous push and pop");
    i_ready = 1'b0;
    applyStimulus(tbl[7]);
    applyStimulus(tbl[8]);
    applyStimulus(tbl[11]);
    waitValid(cyc);
    checkOutput("pp_count_before", 32'(o_count), 32'd2);
    i_ready = 1'b1;
    applyStimulus(tbl[2]);
    i_ready = 1'b0;
    checkOutput("pp_count_after", 32'(o_count), 32'd2);
    i_ready = 1'b1;
    waitDrain();

    $display("[TB] pointer wrap with random commands");
    for (int i = 0; i < 3*DEPTH; i++) begin
      rv = make_vec(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      applyStimulus(rv);
    end
    waitDrain();

    $display("[TB] reset during capture");
    i_ready = 1'b0;
    for (int i = 3; i <= 6; i++) begin
      applyStimulus(tbl[i]);
    end
    checkOutput("pre_reset_count", 32'(o_count), 32'd3);
    i_ready = 1'b1;
    applyStimulus(tbl[8]);
    i_ready = 1'b0;
    step(1);
    checkOutput("capture_queue_count", 32'(o_count), 32'd3);
    i_reset = 1'b0;
    #1;
    checkOutput("midrst_o_valid",   32'(o_valid),     32'd0);
    checkOutput("midrst_o_ready",   32'(o_ready),     32'd0);
    checkOutput("midrst_o_count",   32'(o_count),     32'd0);
    checkOutput("midrst_o_result",  32'(o_result),    32'd0);
    checkOutput("midrst_o_status",  32'(o_status),    32'd0);
    checkOutput("midrst_o_illegal", 32'(o_illegal),   32'd0);
    checkOutput("midrst_o_alu_op",  32'(o_alu_op),    32'd0);
    checkOutput("midrst_o_alu_a",   32'(o_alu_arg_A), 32'd0);
    checkOutput("midrst_o_alu_b",   32'(o_alu_arg_B), 32'd0);
    sb.delete();
    step(2);
    i_reset = 1'b1;
    i_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(1);
      checkOutput("post_reset_no_valid", 32'(o_valid), 32'd0);
    end
    checkOutput("post_reset_ready", 32'(o_ready), 32'd1);
    applyStimulus(tbl[0]);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
